// File: rtl/cache_def.sv
// Shared types for the CPU-side cache path: CPU request/result buses and the
// request-queue state and entry types.
package cache_def;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StGap} q_state_type;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
    } q_entry_type;

    localparam int unsigned TimerW = 8;

    function automatic cpu_req_type issue_req(q_entry_type e);
        return '{addr: e.addr, data: e.data, rw: e.rw, valid: 1'b1};
    endfunction

endpackage

// File: rtl/req_fifo_mem.sv
// Register array holding queued CPU requests: one synchronous write port and one
// asynchronous read port.
module req_fifo_mem
    import cache_def::*;
#(
    parameter int unsigned  DEPTH = 4,
    localparam int unsigned PtrW  = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [PtrW-1:0] waddr_i,
    input  q_entry_type     wdata_i,
    input  logic [PtrW-1:0] raddr_i,
    output q_entry_type     rdata_o
);

    q_entry_type mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_req_queue.sv
// Buffers CPU requests and presents them to the cache one at a time, holding each until
// the cache answers (or times out) and leaving a one-cycle gap before the next issue.
module cpu_req_queue
    import cache_def::*;
#(
    parameter int unsigned  DEPTH   = 4,
    parameter int unsigned  TIMEOUT = 255,
    localparam int unsigned PtrW    = $clog2(DEPTH),
    localparam int unsigned CntW    = PtrW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  cpu_req_type     in_req,
    output logic            in_ready,
    output cpu_req_type     cpu_req,
    input  cpu_result_type  cpu_res,
    output cpu_result_type  resp,
    output logic            resp_rw,
    output logic [CntW-1:0] count,
    output logic            err
);

    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);
    localparam logic [CntW-1:0]   CountFull = CntW'(DEPTH);

    q_state_type       state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              err_q, err_d;
    cpu_req_type       cpu_req_q, cpu_req_d;
    cpu_result_type    resp_q, resp_d;
    logic              resp_rw_q, resp_rw_d;
    logic              push, pop;
    q_entry_type       head, wr_entry;

    // A full queue refuses pushes even in a popping cycle, so in_ready depends on count only.
    assign in_ready = (count_q != CountFull);
    assign push     = in_req.valid && in_ready;
    assign wr_entry = '{addr: in_req.addr, data: in_req.data, rw: in_req.rw};

    req_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        err_d        = err_q;
        cpu_req_d    = cpu_req_q;
        resp_d       = resp_q;
        resp_d.ready = 1'b0;
        resp_rw_d    = resp_rw_q;
        pop          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    cpu_req_d = issue_req(head);
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                // The head stays queued while in flight and is popped on either outcome.
                if (cpu_res.ready) begin
                    resp_d          = '{data: cpu_res.data, ready: 1'b1};
                    resp_rw_d       = cpu_req_q.rw;
                    pop             = 1'b1;
                    cpu_req_d.valid = 1'b0;
                    state_d         = StGap;
                end else if (timer_q == TimerLast) begin
                    err_d           = 1'b1;
                    pop             = 1'b1;
                    cpu_req_d.valid = 1'b0;
                    state_d         = StGap;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            timer_q   <= '0;
            err_q     <= 1'b0;
            cpu_req_q <= '0;
            resp_q    <= '0;
            resp_rw_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            cpu_req_q <= cpu_req_d;
            resp_q    <= resp_d;
            resp_rw_q <= resp_rw_d;
        end
    end

    assign cpu_req = cpu_req_q;
    assign resp    = resp_q;
    assign resp_rw = resp_rw_q;
    assign count   = count_q;
    assign err     = err_q;

endmodule

// File: tb/tb_cpu_req_queue.sv
// Self-checking bench for cpu_req_queue: a holding requester, a cache responder with
// programmable latency, and a queue-level reference model of occupancy and order.
module tb_cpu_req_queue;
    import cache_def::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    cpu_req_type    in_req = '0;
    cpu_result_type cpu_res = '0;
    logic           in_ready;
    cpu_req_type    cpu_req;
    cpu_result_type resp;
    logic           resp_rw;
    logic [2:0]     count;
    logic           err;

    cpu_req_queue #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_req   (in_req),
        .in_ready (in_ready),
        .cpu_req  (cpu_req),
        .cpu_res  (cpu_res),
        .resp     (resp),
        .resp_rw  (resp_rw),
        .count    (count),
        .err      (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    q_entry_type pend[$], model_q[$], push_log[$], issue_log[$];
    bit          busy, rdy_set, stall, noise, gaps, model_err, fix_data;
    bit          ev_done, ev_timeout, ev_issue, ev_rw;
    int          wait_k, lat, cyc;
    logic [31:0] last_data, fix_val, ev_data;

    function automatic q_entry_type mk(logic [31:0] a, logic [31:0] d, logic rw);
        q_entry_type e;
        e.addr = a;
        e.data = d;
        e.rw   = rw;
        return e;
    endfunction

    // Requester holds the head of pend on in_req until accepted (optionally idling).
    task automatic drive_req();
        if (pend.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
            in_req = '{addr: pend[0].addr, data: pend[0].data, rw: pend[0].rw, valid: 1'b1};
        end else begin
            in_req = '0;
        end
    endtask

    // One clock: update the reference model for the edge, then play the cache for the next.
    task automatic tick();
        bit acc;
        acc = in_req.valid && in_ready;
        @(posedge clk);
        #1;
        cyc++;
        ev_done = 0;
        ev_timeout = 0;
        ev_issue = 0;
        if (acc) begin
            push_log.push_back(pend[0]);
            model_q.push_back(pend.pop_front());
        end
        if (busy) begin
            wait_k++;
            if (rdy_set) begin
                ev_done = 1;
                ev_data = last_data;
                ev_rw = model_q[0].rw;
                void'(model_q.pop_front());
                busy = 0;
            end else if (wait_k == 1 + TMO) begin
                ev_timeout = 1;
                model_err = 1;
                void'(model_q.pop_front());
                busy = 0;
            end
        end
        rdy_set = 0;
        cpu_res.ready = 1'b0;
        cpu_res.data = $urandom;
        if (!busy && cpu_req.valid) begin
            busy = 1;
            wait_k = 0;
            ev_issue = 1;
            issue_log.push_back(mk(cpu_req.addr, cpu_req.data, cpu_req.rw));
        end else if (busy && !stall && wait_k == 1 + lat) begin
            cpu_res.ready = 1'b1;
            if (fix_data) cpu_res.data = fix_val;
            last_data = cpu_res.data;
            rdy_set = 1;
        end else if (!busy && noise) begin
            cpu_res.ready = 1'($urandom_range(0, 1));
        end
        drive_req();
    endtask

    task automatic drain(output bit timed_out);
        timed_out = 1;
        for (int i = 0; i < 400; i++) begin
            if (pend.size() == 0 && model_q.size() == 0 && !busy) begin
                timed_out = 0;
                break;
            end
            tick();
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        in_req = '0;
        cpu_res = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        pend.delete();
        model_q.delete();
        push_log.delete();
        issue_log.delete();
        busy = 0;
        rdy_set = 0;
        model_err = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (cpu_req !== '0) begin n_errors++; $display("FAIL reset_cpu_req: got %h want 0", cpu_req); end
        n_checks++; if (resp !== '0) begin n_errors++; $display("FAIL reset_resp: got %h want 0", resp); end
        n_checks++; if (resp_rw !== 1'b0) begin n_errors++; $display("FAIL reset_resp_rw: got %b want 0", resp_rw); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tick();
        n_checks++; if (cpu_req.valid !== 1'b0) begin n_errors++; $display("FAIL idle_valid: got %b want 0", cpu_req.valid); end
    endtask

    task automatic test_single_read();
        int t_issue, t_done;
        bit to;
        stall = 0; noise = 0; gaps = 0; lat = 3; fix_data = 1; fix_val = 32'hDEAD_BEEF;
        pend.push_back(mk(32'h0000_0040, 32'h0, 1'b0));
        drive_req();
        t_issue = -1; t_done = -1; cyc = 0;
        for (int i = 0; i < 30 && t_done < 0; i++) begin
            tick();
            if (ev_issue) t_issue = cyc;
            if (cyc == 1) begin
                n_checks++; if (count !== 3'd1) begin n_errors++; $display("FAIL single_count_up: got %0d want 1", count); end
            end
            n_checks++;
            if (resp.ready !== ev_done) begin
                n_errors++; $display("FAIL single_resp_ready cyc%0d: got %b want %b", cyc, resp.ready, ev_done);
            end
            if (ev_done) begin
                t_done = cyc;
                n_checks++; if (resp.data !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL single_data: got %h want deadbeef", resp.data); end
                n_checks++; if (resp_rw !== 1'b0) begin n_errors++; $display("FAIL single_rw: got %b want 0", resp_rw); end
                n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL single_count_down: got %0d want 0", count); end
            end
        end
        n_checks++; if (t_issue != 2) begin n_errors++; $display("FAIL single_issue_cycle: got %0d want 2", t_issue); end
        n_checks++; if (t_done != t_issue + 2 + lat) begin n_errors++; $display("FAIL single_done_cycle: got %0d want %0d", t_done, t_issue + 2 + lat); end
        tick();
        n_checks++; if (resp.ready !== 1'b0 || resp.data !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL single_resp_hold: got %b/%h want 0/deadbeef", resp.ready, resp.data); end
        fix_data = 0;
        drain(to);
    endtask

    task automatic test_fill_backpressure();
        int first_done, acc5, psize;
        bit to;
        push_log.delete(); issue_log.delete();
        stall = 0; noise = 0; gaps = 0; lat = 6;
        for (int i = 0; i < 5; i++) pend.push_back(mk(32'h200 + 32'(i * 4), $urandom, 1'($urandom_range(0, 1))));
        drive_req();
        cyc = 0;
        repeat (4) tick();
        n_checks++; if (count !== 3'd4) begin n_errors++; $display("FAIL fill_count: got %0d want 4", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        first_done = -1; acc5 = -1;
        for (int i = 0; i < 40 && acc5 < 0; i++) begin
            psize = pend.size();
            tick();
            if (ev_done && first_done < 0) first_done = cyc;
            if (pend.size() < psize) acc5 = cyc;
            n_checks++;
            if (in_ready !== (model_q.size() != DEPTH)) begin
                n_errors++; $display("FAIL fill_ready_track cyc%0d: got %b want %b", cyc, in_ready, model_q.size() != DEPTH);
            end
        end
        n_checks++;
        if (first_done < 0 || acc5 != first_done + 1) begin
            n_errors++; $display("FAIL fill_fifth_accept: got cyc %0d want %0d", acc5, first_done + 1);
        end
        drain(to);
        n_checks++; if (to) begin n_errors++; $display("FAIL fill_drain: timed out, %0d left", model_q.size()); end
        n_checks++; if (issue_log.size() != 5) begin n_errors++; $display("FAIL fill_issue_count: got %0d want 5", issue_log.size()); end
        for (int i = 0; i < push_log.size() && i < issue_log.size(); i++) begin
            n_checks++;
            if (issue_log[i] !== push_log[i]) begin n_errors++; $display("FAIL fill_order[%0d]: got %h want %h", i, issue_log[i], push_log[i]); end
        end
    endtask

    task automatic test_wrap();
        int n_done;
        push_log.delete(); issue_log.delete();
        stall = 0; noise = 0; gaps = 0; lat = 1; n_done = 0;
        for (int i = 0; i < 10; i++) pend.push_back(mk(32'h100 + 32'(4 * i), $urandom, 1'b1));
        drive_req();
        for (int i = 0; i < 400 && n_done < 10; i++) begin
            tick();
            if (ev_issue) lat = $urandom_range(0, 4);
            n_checks++; if (count !== 3'(model_q.size())) begin n_errors++; $display("FAIL wrap_count: got %0d want %0d", count, model_q.size()); end
            if (ev_done) begin
                n_done++;
                n_checks++;
                if (resp.ready !== 1'b1 || resp_rw !== 1'b1 || resp.data !== ev_data) begin
                    n_errors++; $display("FAIL wrap_resp: got %b/%b/%h want 1/1/%h", resp.ready, resp_rw, resp.data, ev_data);
                end
            end
        end
        n_checks++; if (n_done != 10) begin n_errors++; $display("FAIL wrap_done: got %0d want 10", n_done); end
        for (int i = 0; i < 10 && i < issue_log.size(); i++) begin
            n_checks++;
            if (issue_log[i].addr !== 32'h100 + 32'(4 * i) || issue_log[i] !== push_log[i]) begin
                n_errors++; $display("FAIL wrap_order[%0d]: got %h want %h", i, issue_log[i].addr, 32'h100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_push_pop();
        q_entry_type b;
        int done_cyc, iss_cyc;
        bit found, to;
        push_log.delete(); issue_log.delete();
        stall = 0; noise = 0; gaps = 0; lat = 5;
        b = mk(32'h0000_0B00, $urandom, 1'b0);
        pend.push_back(mk(32'h0000_0A00, $urandom, 1'b1));
        pend.push_back(b);
        drive_req();
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            found = (model_q.size() == 2) && rdy_set;
        end
        n_checks++; if (!found) begin n_errors++; $display("FAIL pp_setup: got no completion window want one"); end
        pend.push_back(mk(32'h0000_0C00, $urandom, 1'b0));
        drive_req();
        tick();
        done_cyc = cyc;
        n_checks++; if (!ev_done || count !== 3'd2) begin n_errors++; $display("FAIL pp_count: got %0d want 2", count); end
        tick();
        n_checks++; if (cpu_req.valid !== 1'b0) begin n_errors++; $display("FAIL pp_gap: got valid %b want 0", cpu_req.valid); end
        iss_cyc = -1;
        for (int i = 0; i < 10 && iss_cyc < 0; i++) begin
            if (ev_issue) iss_cyc = cyc;
            else tick();
        end
        n_checks++; if (iss_cyc != done_cyc + 2) begin n_errors++; $display("FAIL pp_issue_cycle: got %0d want %0d", iss_cyc, done_cyc + 2); end
        n_checks++;
        if (issue_log.size() < 2 || issue_log[issue_log.size() - 1] !== b) begin
            n_errors++; $display("FAIL pp_next: got %h want %h", cpu_req.addr, b.addr);
        end
        drain(to);
        n_checks++; if (to) begin n_errors++; $display("FAIL pp_drain: timed out"); end
    endtask

    task automatic test_timeout();
        int to_cyc;
        bit to;
        push_log.delete(); issue_log.delete();
        stall = 1; noise = 0; gaps = 0; lat = 1;
        pend.push_back(mk(32'h0000_3000, $urandom, 1'b0));
        pend.push_back(mk(32'h0000_3004, $urandom, 1'b1));
        drive_req();
        to_cyc = -1;
        for (int i = 0; i < 60 && (model_q.size() != 0 || pend.size() != 0 || busy); i++) begin
            tick();
            if (ev_timeout) begin
                to_cyc = cyc;
                stall = 0;
            end
            n_checks++; if (err !== model_err) begin n_errors++; $display("FAIL to_err cyc%0d: got %b want %b", cyc, err, model_err); end
            n_checks++; if (count !== 3'(model_q.size())) begin n_errors++; $display("FAIL to_count: got %0d want %0d", count, model_q.size()); end
            n_checks++; if (resp.ready !== ev_done) begin n_errors++; $display("FAIL to_resp cyc%0d: got %b want %b", cyc, resp.ready, ev_done); end
        end
        n_checks++; if (to_cyc < 0) begin n_errors++; $display("FAIL to_seen: got no timeout want one"); end
        n_checks++;
        if (issue_log.size() != 2 || issue_log[1] !== push_log[1]) begin
            n_errors++; $display("FAIL to_next_issue: got %0d issues want 2 in order", issue_log.size());
        end
        drain(to);
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL to_sticky: got %b want 1", err); end
    endtask

    task automatic test_reset_mid();
        bit found;
        stall = 0; noise = 0; gaps = 0; lat = 6;
        for (int i = 0; i < 3; i++) pend.push_back(mk(32'h4000 + 32'(i), $urandom, 1'b0));
        drive_req();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = busy && wait_k >= 2 && model_q.size() == 3;
        end
        n_checks++; if (!found) begin n_errors++; $display("FAIL rm_setup: got no WAIT window want one"); end
        apply_reset();
        n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL rm_count: got %0d want 0", count); end
        n_checks++; if (cpu_req.valid !== 1'b0) begin n_errors++; $display("FAIL rm_valid: got %b want 0", cpu_req.valid); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rm_err: got %b want 0", err); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
        repeat (3) tick();
        n_checks++; if (cpu_req.valid !== 1'b0 || count !== 3'd0) begin n_errors++; $display("FAIL rm_abandon: got valid %b count %0d want 0/0", cpu_req.valid, count); end
    endtask

    task automatic test_random();
        bit to;
        push_log.delete(); issue_log.delete();
        stall = 0; noise = 1; gaps = 1; lat = 2;
        for (int i = 0; i < 500; i++) begin
            if (i < 400 && pend.size() < 3 && $urandom_range(0, 2) == 0) begin
                pend.push_back(mk($urandom, $urandom, 1'($urandom_range(0, 1))));
            end
            tick();
            if (ev_issue) lat = $urandom_range(0, 5);
            n_checks++; if (count !== 3'(model_q.size())) begin n_errors++; $display("FAIL rnd_count cyc%0d: got %0d want %0d", cyc, count, model_q.size()); end
            n_checks++; if (in_ready !== (model_q.size() != DEPTH)) begin n_errors++; $display("FAIL rnd_in_ready: got %b want %b", in_ready, model_q.size() != DEPTH); end
            n_checks++; if (resp.ready !== ev_done) begin n_errors++; $display("FAIL rnd_resp cyc%0d: got %b want %b", cyc, resp.ready, ev_done); end
            if (ev_done) begin
                n_checks++;
                if (resp.data !== ev_data || resp_rw !== ev_rw) begin
                    n_errors++; $display("FAIL rnd_resp_data: got %h/%b want %h/%b", resp.data, resp_rw, ev_data, ev_rw);
                end
            end
            if (busy) begin
                n_checks++;
                if (cpu_req.valid !== 1'b1 || mk(cpu_req.addr, cpu_req.data, cpu_req.rw) !== issue_log[issue_log.size() - 1]) begin
                    n_errors++; $display("FAIL rnd_hold: got %h valid %b want stable request", cpu_req.addr, cpu_req.valid);
                end
            end
            n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rnd_err: got %b want 0", err); end
        end
        gaps = 0;
        drain(to);
        n_checks++; if (to) begin n_errors++; $display("FAIL rnd_drain: timed out"); end
        n_checks++; if (issue_log.size() != push_log.size()) begin n_errors++; $display("FAIL rnd_issue_count: got %0d want %0d", issue_log.size(), push_log.size()); end
        for (int i = 0; i < push_log.size() && i < issue_log.size(); i++) begin
            n_checks++;
            if (issue_log[i] !== push_log[i]) begin n_errors++; $display("FAIL rnd_order[%0d]: got %h want %h", i, issue_log[i], push_log[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fill_backpressure();
        test_wrap();
        test_push_pop();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_req_queue.md
# cpu_req_queue

Request queue between the CPU-side requester (testcase or core model) and `dm_cache_fsm`. It buffers up to `DEPTH` CPU requests and presents them to the cache one at a time on `cpu_req`. Each request is held stable until the cache answers on `cpu_res.ready`. The block then returns the result to the requester and inserts a one-cycle idle gap before issuing the next request.

## Interface
Parameters:
- `DEPTH`, 4: number of queue entries; power of two, at least 2.
- `TIMEOUT`, 255: maximum cycles in WAIT before `err` is raised; must fit in 8 bits.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_req`  in  cpu_req_type  requester request (`addr`, `data`, `rw`, `valid`).
- `in_ready`  out  1  queue can accept a request this cycle.
- `cpu_req`  out  cpu_req_type  request to the cache (drives `cache_intf.cpu_req`).
- `cpu_res`  in  cpu_result_type  cache result (`data`, `ready`).
- `resp`  out  cpu_result_type  result returned to the requester; `resp.ready` is a 1-cycle pulse.
- `resp_rw`  out  1  `rw` of the completed request; valid while `resp.ready` is 1.
- `count`  out  $clog2(DEPTH)+1  occupied entries, including the entry in flight.
- `err`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- Storage: circular buffer of `DEPTH` entries, each holding `{addr, data, rw}`.
  - Pointers `wr_ptr` and `rd_ptr` are `$clog2(DEPTH)` bits wide and wrap naturally.
  - `count` is tracked separately.
- Push: occurs when `in_req.valid && in_ready`. The entry is written at `wr_ptr`, then `wr_ptr++`.
- `in_ready = (count != DEPTH)`. It is combinational from `count` only.
  - When full, no push is accepted, even in a cycle that pops.
  - The requester must hold its request until `in_ready` is 1; it is not dropped silently.
- The head entry stays in the queue while in flight. It is popped (`rd_ptr++`, `count--`) only on completion.
- Simultaneous push and pop: `count` is unchanged, and both pointers advance.
- FSM states: IDLE, ISSUE, WAIT, GAP.
  - IDLE: `cpu_req.valid=0`. If `count!=0`, load `cpu_req` from the head and set `valid=1`, then go to ISSUE.
  - ISSUE: a single cycle with the request on the bus. Clear the timeout counter, then go to WAIT.
  - WAIT: hold `cpu_req` stable and increment the timeout counter.
    - On `cpu_res.ready=1`: capture `cpu_res.data`, pulse `resp.ready`, pop the head, set `cpu_req.valid=0`, go to GAP.
    - If the counter reaches `TIMEOUT`: set `err`, pop the head, set `cpu_req.valid=0`, go to GAP. No `resp` pulse is produced.
  - GAP: `cpu_req.valid=0` for exactly one cycle, then go to IDLE.
- `cpu_res.ready` is ignored in every state other than WAIT.
- `resp.data` holds its last value until the next completion.
  - For writes, `resp.data` carries whatever the cache returns; `resp_rw=1` marks the result as a write acknowledgement.

## Timing
- Reset (`rst=0` at an edge):
  - FSM goes to IDLE; pointers = 0; `count` = 0; `err` = 0.
  - `cpu_req` = all zeros (`valid=0`); `resp` = all zeros; `resp_rw` = 0.
- Reset mid-request abandons the in-flight and all queued entries. The cache is reset by the same `rst`.
- All outputs except `in_ready` are registered.
- Push into an empty queue at edge N:
  - `count=1` after N.
  - `cpu_req.valid=1` after N+1.
  - WAIT entered at N+2.
- Cache asserts `ready` sampled at edge M: `resp.ready=1` and `count` decremented after M. `cpu_req.valid=0` from M through M+1 (GAP).
- Minimum spacing between consecutive `cpu_req.valid` rising edges: 4 cycles plus cache latency.

## Structure
- The following belong in the `cache_def` package:
  - `cpu_req_type` and `cpu_result_type` (already present).
  - New `typedef enum {IDLE, ISSUE, WAIT, GAP} q_state_type`.
  - New `typedef struct {addr, data, rw} q_entry_type`.
- One sub-module: `req_fifo_mem`, a `DEPTH`×`q_entry_type` register array with one write port and one asynchronous read port.
- Top-level wiring: `in_req`/`resp` connect to `cache_intf.CACHE_IN`/`CACHE_OUT`, and the block sits between the testcase and the DUT.

## Test plan
- Single read:
  - Stimulus: push `addr=0x0000_0040`, `rw=0` into an empty queue; cache model answers 3 cycles after WAIT with `data=0xDEAD_BEEF`.
  - Required: `resp.ready` pulse with `data=0xDEAD_BEEF`, `resp_rw=0`; `count` goes 1→0.
- Fill and back-pressure:
  - Stimulus: with the cache stalled, push 5 requests back-to-back (`DEPTH=4`).
  - Required: `in_ready=0` after the 4th push; the 5th is held by the requester and accepted only after the first completion; issue order equals push order.
- Pointer wrap:
  - Stimulus: 10 sequential writes with addresses 0x100 + 4·i.
  - Required: issue order is preserved across the `rd_ptr` 3→0 wrap.
- Push/pop same cycle:
  - Stimulus: `count=2`; push in the same cycle as the completion.
  - Required: `count` stays 2; the next issue is the old second entry.
- Timeout:
  - Stimulus: `TIMEOUT=8`; the cache never asserts `ready`.
  - Required: `err=1` after 8 WAIT cycles; head popped; next request issued; no `resp` pulse.
- Reset mid-WAIT:
  - Stimulus: `rst=0` for 1 cycle while 3 requests are queued.
  - Required: next cycle `count=0`, `cpu_req.valid=0`, `err=0`, `in_ready=1`.
